// File: rtl/note_tone_generator_if.sv
// Sample-strobe / note-code bus for the tone generator.
// The driver side owns the strobe and note; the generator owns the sample outputs.
interface note_tone_generator_if;
  logic        SampleStrobe;
  logic [7:0]  NoteData;
  logic [31:0] Sample;
  logic        SampleValid;
  logic        Active;

  modport master (
    output SampleStrobe, NoteData,
    input  Sample, SampleValid, Active
  );

  modport slave (
    input  SampleStrobe, NoteData,
    output Sample, SampleValid, Active
  );
endinterface

// File: rtl/note_tone_generator.sv
// Square-wave note generator: 24-bit phase accumulator plus amplitude envelope.
// Define TONE_ENVELOPE_EN for attack/release ramps; otherwise notes gate on/off.
module note_tone_generator #(
  parameter logic [15:0] AMP_MAX      = 16'h1000,
  parameter logic [15:0] ATTACK_STEP  = 16'd64,
  parameter logic [15:0] RELEASE_STEP = 16'd32
) (
  input logic                   MasterCLK,
  input logic                   Reset,
  note_tone_generator_if.slave  tone
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SUSTAIN = 2'd2;
`ifdef TONE_ENVELOPE_EN
  localparam logic [1:0] ATTACK  = 2'd1;
  localparam logic [1:0] RELEASE = 2'd3;
`endif

  logic [1:0]  r_state;
  logic [23:0] r_phase;
  logic [15:0] r_amp;
  logic [6:0]  r_note;
  logic        r_pend;
  logic        r_valid;
  logic [31:0] r_sample;

  logic [1:0]  w_state_n;
  logic [23:0] w_phase_n;
  logic [15:0] w_amp_n;
  logic [6:0]  w_note_n;
  logic        w_valid;
  logic        w_new;
  logic [6:0]  w_sel;
  logic [23:0] w_inc;
  logic [15:0] w_mag;

  // Octave-0 increments: round(f * 2^24 / 41000), C0..B0
  function automatic logic [23:0] rom(input logic [3:0] i);
    case (i)
      4'd1:    rom = 24'd6691;
      4'd2:    rom = 24'd7089;
      4'd3:    rom = 24'd7510;
      4'd4:    rom = 24'd7957;
      4'd5:    rom = 24'd8430;
      4'd6:    rom = 24'd8932;
      4'd7:    rom = 24'd9463;
      4'd8:    rom = 24'd10025;
      4'd9:    rom = 24'd10621;
      4'd10:   rom = 24'd11253;
      4'd11:   rom = 24'd11922;
      4'd12:   rom = 24'd12631;
      default: rom = 24'd0;
    endcase
  endfunction

  assign w_valid = (tone.NoteData[3:0] >= 4'd1)
                && (tone.NoteData[3:0] <= 4'd12);
  assign w_new = w_valid && ((r_state == IDLE)
              || (tone.NoteData[6:0] != r_note));
  // A rest keeps the latched pitch sounding through the release tail
  assign w_sel = w_valid ? tone.NoteData[6:0] : r_note;
  assign w_inc = rom(w_sel[3:0]) << w_sel[6:4];

`ifdef TONE_ENVELOPE_EN
  logic [16:0] w_att;
  logic        w_att_sat;
  logic        w_rel_zero;

  assign w_att = {1'b0, r_amp} + {1'b0, ATTACK_STEP};
  assign w_att_sat = (w_att >= {1'b0, AMP_MAX});
  assign w_rel_zero = (r_amp <= RELEASE_STEP);

  always_comb begin
    w_state_n = r_state;
    w_amp_n   = r_amp;
    w_note_n  = r_note;
    w_phase_n = r_phase + w_inc;
    if (w_new) begin
      w_phase_n = w_inc;
      w_note_n  = tone.NoteData[6:0];
      w_state_n = w_att_sat ? SUSTAIN : ATTACK;
      w_amp_n   = w_att_sat ? AMP_MAX : w_att[15:0];
    end else if (r_state == IDLE) begin
      w_phase_n = r_phase;
    end else if (!w_valid || r_state == RELEASE) begin
      if (w_rel_zero) begin
        w_state_n = IDLE;
        w_amp_n   = 16'd0;
        w_phase_n = 24'd0;
        w_note_n  = 7'd0;
      end else begin
        w_state_n = RELEASE;
        w_amp_n   = r_amp - RELEASE_STEP;
      end
    end else if (r_state == ATTACK) begin
      w_state_n = w_att_sat ? SUSTAIN : ATTACK;
      w_amp_n   = w_att_sat ? AMP_MAX : w_att[15:0];
    end
  end
`else
  always_comb begin
    w_state_n = r_state;
    w_amp_n   = r_amp;
    w_note_n  = r_note;
    w_phase_n = r_phase + w_inc;
    if (w_new) begin
      w_phase_n = w_inc;
      w_note_n  = tone.NoteData[6:0];
      w_state_n = SUSTAIN;
      w_amp_n   = AMP_MAX;
    end else if (!w_valid) begin
      w_state_n = IDLE;
      w_amp_n   = 16'd0;
      w_phase_n = 24'd0;
      w_note_n  = 7'd0;
    end
  end
`endif

  assign w_mag = r_phase[23] ? (~r_amp + 16'd1) : r_amp;

  always_ff @(posedge MasterCLK) begin
    if (Reset) begin
      r_state  <= IDLE;
      r_phase  <= 24'd0;
      r_amp    <= 16'd0;
      r_note   <= 7'd0;
      r_pend   <= 1'b0;
      r_valid  <= 1'b0;
      r_sample <= 32'd0;
    end else begin
      r_pend  <= tone.SampleStrobe;
      r_valid <= r_pend;
      if (tone.SampleStrobe) begin
        r_state <= w_state_n;
        r_phase <= w_phase_n;
        r_amp   <= w_amp_n;
        r_note  <= w_note_n;
      end
      if (r_pend)
        r_sample <= {w_mag, w_mag};
    end
  end

  assign tone.Sample      = r_sample;
  assign tone.SampleValid = r_valid;
  assign tone.Active      = (r_state != IDLE);

endmodule

// File: tb/tb_note_tone_generator.sv
// Bench for note_tone_generator: vector table, reference model and
// a sample scoreboard checked against every SampleValid pulse.
module tb_note_tone_generator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  note_tone_generator_if bus();

  note_tone_generator dut (
    .MasterCLK (clk),
    .Reset     (rst),
    .tone      (bus)
  );

  localparam logic [15:0] AMP = 16'h1000;
  localparam int AS = 64;
  localparam int RS = 32;
`ifdef TONE_ENVELOPE_EN
  localparam int REL_N = 128;
  localparam logic [31:0] RETRIG = 32'h0240_0240;
  localparam logic [31:0] FRESH  = 32'h0040_0040;
`else
  localparam int REL_N = 1;
  localparam logic [31:0] RETRIG = 32'h1000_1000;
  localparam logic [31:0] FRESH  = 32'h1000_1000;
`endif

  typedef struct {
    logic [31:0] s;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [7:0]  note;
    logic [31:0] s;
    logic        act;
  } vec_t;

  exp_t q[$];
  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  logic [31:0] last_s = 32'd0;

  int rom[16] = '{0, 6691, 7089, 7510, 7957, 8430, 8932, 9463,
                  10025, 10621, 11253, 11922, 12631, 0, 0, 0};
  int          m_st;
  logic [15:0] m_amp;
  logic [23:0] m_ph;
  logic [6:0]  m_note;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string nm,
                     input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h, want %h", nm, act, req);
  endtask

  always @(negedge clk) begin
    if (bus.SampleValid === 1'b1) begin
      if (q.size() == 0) begin
        chk(1'b0, "unexpected_valid", bus.Sample, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk(bus.Sample === e.s, "sample", bus.Sample, e.s);
        chk(cyc - e.cyc == 2, "latency", cyc - e.cyc, 2);
      end
      last_s = bus.Sample;
    end
  end

  task automatic m_reset();
    m_st = 0; m_amp = 0; m_ph = 0; m_note = 0;
  endtask

  task automatic m_att();
    if (int'(m_amp) + AS >= int'(AMP)) begin
      m_amp = AMP; m_st = 2;
    end else begin
      m_amp = m_amp + 16'(AS); m_st = 1;
    end
  endtask

  task automatic m_rel();
    if (int'(m_amp) <= RS) begin
      m_amp = 0; m_st = 0; m_ph = 0; m_note = 0;
    end else begin
      m_amp = m_amp - 16'(RS); m_st = 3;
    end
  endtask

  task automatic model(input logic [7:0] n, output logic [31:0] e);
    logic [3:0]  ix;
    bit          v;
    logic [6:0]  sel;
    logic [23:0] inc;
    logic [15:0] a;
    ix  = n[3:0];
    v   = (ix >= 1) && (ix <= 12);
    sel = v ? n[6:0] : m_note;
    inc = 24'(rom[sel[3:0]]) << sel[6:4];
`ifdef TONE_ENVELOPE_EN
    if (v && (m_st == 0 || n[6:0] != m_note)) begin
      m_ph = inc; m_note = n[6:0]; m_att();
    end else if (m_st != 0) begin
      m_ph = m_ph + inc;
      if (!v || m_st == 3) m_rel();
      else if (m_st == 1) m_att();
    end
`else
    if (v && (m_st == 0 || n[6:0] != m_note)) begin
      m_ph = inc; m_note = n[6:0]; m_amp = AMP; m_st = 2;
    end else if (v) begin
      m_ph = m_ph + inc;
    end else begin
      m_ph = 0; m_amp = 0; m_st = 0; m_note = 0;
    end
`endif
    a = m_ph[23] ? 16'(-m_amp) : m_amp;
    e = {a, a};
  endtask

  // Non-strobe cycles carry random NoteData that must be ignored
  task automatic strobe(input logic [7:0] n, input logic [31:0] e);
    exp_t x;
    x.s = e; x.cyc = cyc;
    q.push_back(x);
    bus.NoteData = n;
    bus.SampleStrobe = 1'b1;
    @(negedge clk);
    bus.SampleStrobe = 1'b0;
    bus.NoteData = 8'($urandom);
    chk(bus.Active === (m_st != 0), "active", 32'(bus.Active),
        32'(m_st != 0));
    @(negedge clk);
  endtask

  task automatic step(input logic [7:0] n);
    logic [31:0] e;
    model(n, e);
    strobe(n, e);
  endtask

  initial begin
    vec_t vt[5];
    int   fall;
    int   n;
    logic [15:0] mag;
    logic [31:0] e1, e2;
    exp_t x;

`ifdef TONE_ENVELOPE_EN
    vt[0] = '{8'h4D, 32'h0000_0000, 1'b0};
    vt[1] = '{8'h00, 32'h0000_0000, 1'b0};
    vt[2] = '{8'h4A, 32'h0040_0040, 1'b1};
    vt[3] = '{8'hCA, 32'h0080_0080, 1'b1};
    vt[4] = '{8'h4A, 32'h00C0_00C0, 1'b1};
`else
    vt[0] = '{8'h4D, 32'h0000_0000, 1'b0};
    vt[1] = '{8'h00, 32'h0000_0000, 1'b0};
    vt[2] = '{8'h4A, 32'h1000_1000, 1'b1};
    vt[3] = '{8'hCA, 32'h1000_1000, 1'b1};
    vt[4] = '{8'h4A, 32'h1000_1000, 1'b1};
`endif

    bus.SampleStrobe = 1'b0;
    bus.NoteData = 8'h4A;
    m_reset();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      bus.SampleStrobe = ~bus.SampleStrobe;
      @(negedge clk);
      chk(bus.Sample === 32'd0 && bus.SampleValid === 1'b0
          && bus.Active === 1'b0, "reset_outputs",
          bus.Sample, 32'd0);
    end
    bus.SampleStrobe = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      model(vt[i].note, e1);
      strobe(vt[i].note, vt[i].s);
      chk(bus.Active === vt[i].act, "tbl_active",
          32'(bus.Active), 32'(vt[i].act));
    end

    n = 0;
    while (m_st != 2 && n < 100) begin
      step(8'h4A);
      n++;
    end
    @(negedge clk);
    mag = last_s[15] ? 16'(-last_s[15:0]) : last_s[15:0];
    chk(mag == AMP && last_s[31:16] == last_s[15:0],
        "sustain_amp", last_s, 32'(AMP));

    for (int i = 0; i < 200; i++) step(8'h4A);

    fall = 0;
    for (int i = 1; i <= 140; i++) begin
      step(8'h00);
      if (fall == 0 && bus.Active === 1'b0) fall = i;
    end
    chk(fall == REL_N, "release_len", fall, REL_N);

    for (int i = 0; i < 8; i++) step(8'h4A);
    step(8'h41);
    @(negedge clk);
    chk(last_s === RETRIG, "retrigger", last_s, RETRIG);
    step(8'h41);

    model(8'h41, e1);
    model(8'h41, e2);
    x.s = e1; x.cyc = cyc; q.push_back(x);
    x.s = e2; x.cyc = cyc + 1; q.push_back(x);
    bus.NoteData = 8'h41;
    bus.SampleStrobe = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.SampleStrobe = 1'b0;
    @(negedge clk);

    rst = 1'b1;
    bus.SampleStrobe = 1'b1;
    bus.NoteData = 8'h45;
    @(negedge clk);
    rst = 1'b0;
    bus.SampleStrobe = 1'b0;
    m_reset();
    chk(bus.Sample === 32'd0 && bus.Active === 1'b0
        && bus.SampleValid === 1'b0, "reset_midnote",
        bus.Sample, 32'd0);
    @(negedge clk);
    chk(bus.SampleValid === 1'b0, "reset_no_valid",
        32'(bus.SampleValid), 32'd0);

    step(8'h4D);
    step(8'h4A);
    @(negedge clk);
    chk(last_s === FRESH, "fresh_attack", last_s, FRESH);

    repeat (4) @(negedge clk);
    chk(q.size() == 0, "drain", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
